// File: rtl/pipeline_collector_pkg.sv
// Shared widths and the stored entry layout for the pipeline result collector.
package pipeline_collector_pkg;

    localparam int DATA_W = 12;
    localparam int ADR_W  = 13;
    localparam int CSUM_W = 16;

    typedef struct packed {
        logic [ADR_W-1:0]  adr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/collector_fifo.sv
// First-word-fall-through storage for collected results: memory, pointers and level.
// DEPTH must be a power of two so the pointers wrap naturally.
module collector_fifo
    import pipeline_collector_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             i_rst,
    input  entry_t           i_wr_entry,
    input  logic             i_wr_valid,
    input  logic             i_rd_ready,
    output entry_t           o_rd_entry,
    output logic             o_rd_valid,
    output logic [LVL_W-1:0] o_level,
    output logic             o_push
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    entry_t           r_mem [DEPTH];

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full = (r_level == LVL_W'(DEPTH));
    assign w_pop  = (r_level != '0) && i_rd_ready;
    // A full FIFO still accepts a word when the head retires on the same edge.
    assign w_push = i_wr_valid && (!w_full || w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (w_pop && !w_push) r_level <= r_level - LVL_W'(1);
        end
    end

    // NOTE: the memory array has no reset; empty slots are never observable
    // because the head is masked to zero whenever the level is zero.
    always_ff @(posedge clk) begin
        if (!i_rst && w_push) r_mem[r_wr_ptr] <= i_wr_entry;
    end

    assign o_rd_valid = (r_level != '0);
    assign o_rd_entry = o_rd_valid ? r_mem[r_rd_ptr] : '0;
    assign o_level    = r_level;
    assign o_push     = w_push;

endmodule

// File: rtl/pipeline_result_collector.sv
// Collects upstream pipeline results into a FWFT FIFO with overflow tracking.
// Define COLLECTOR_CHECKSUM_EN to build the running checksum of accepted words.
module pipeline_result_collector
    import pipeline_collector_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int DROP_W = 8,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              pon_rst_i,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic [ADR_W-1:0]  in_adr,
    output logic [DATA_W-1:0] out_data,
    output logic [ADR_W-1:0]  out_adr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LVL_W-1:0]  level,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [CSUM_W-1:0] checksum
);

    entry_t w_in_entry;
    entry_t w_head;
    logic   w_push;
    logic   w_drop;

    logic              r_ovf;
    logic [DROP_W-1:0] r_drop_cnt;

    assign w_in_entry = '{adr: in_adr, data: in_data};

    collector_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .i_rst      (pon_rst_i),
        .i_wr_entry (w_in_entry),
        .i_wr_valid (in_valid),
        .i_rd_ready (out_ready),
        .o_rd_entry (w_head),
        .o_rd_valid (out_valid),
        .o_level    (level),
        .o_push     (w_push)
    );

    assign w_drop = in_valid && !w_push;

    // A drop in the same cycle as a clear wins: the flag stays set and the count restarts at one.
    always_ff @(posedge clk) begin
        if (pon_rst_i) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr)               r_drop_cnt <= DROP_W'(1);
            else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

`ifdef COLLECTOR_CHECKSUM_EN
    logic [CSUM_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (pon_rst_i)   r_checksum <= '0;
        else if (w_push) r_checksum <= r_checksum + CSUM_W'(in_data);
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign out_data = w_head.data;
    assign out_adr  = w_head.adr;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_pipeline_result_collector.sv
// Scoreboard bench for pipeline_result_collector (DEPTH=8, DROP_W=8); honours COLLECTOR_CHECKSUM_EN.
module tb_pipeline_result_collector;
    import pipeline_collector_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        pon_rst_i, in_valid, out_ready, ovf_clr;
    logic [11:0] in_data;
    logic [12:0] in_adr;
    logic [11:0] out_data;
    logic [12:0] out_adr;
    logic        out_valid, ovf;
    logic [3:0]  level;
    logic [7:0]  drop_cnt;
    logic [15:0] checksum;

    int n_tests = 0;
    int n_fail  = 0;

    entry_t      q[$];
    logic        m_ovf;
    logic [7:0]  m_drop;
    logic [15:0] m_csum;

    always #5 clk = ~clk;

    pipeline_result_collector #(.DEPTH(DEPTH), .DROP_W(8)) dut (
        .clk(clk), .pon_rst_i(pon_rst_i), .in_data(in_data), .in_valid(in_valid),
        .in_adr(in_adr), .out_data(out_data), .out_adr(out_adr), .out_valid(out_valid),
        .out_ready(out_ready), .level(level), .ovf(ovf), .ovf_clr(ovf_clr),
        .drop_cnt(drop_cnt), .checksum(checksum)
    );

    function automatic logic [15:0] exp_csum(input logic [15:0] enabled_value);
`ifdef COLLECTOR_CHECKSUM_EN
        return enabled_value;
`else
        return 16'h0000;
`endif
    endfunction

    // Advance one clock: update the model from the driven inputs, retire popped heads, sample #1 after the edge.
    task automatic cycle();
        bit pop, push, drop;
        if (pon_rst_i) begin
            q.delete();
            m_ovf  = 1'b0;
            m_drop = 8'h00;
            m_csum = 16'h0000;
        end else begin
            pop  = (q.size() != 0) && out_ready;
            push = in_valid && ((q.size() < DEPTH) || pop);
            drop = in_valid && !push;
            if (pop) begin
                n_tests++;
                if (out_data !== q[0].data || out_adr !== q[0].adr) begin
                    n_fail++;
                    $display("FAIL pop_order: got %h@%h expected %h@%h", out_data, out_adr, q[0].data, q[0].adr);
                end
                void'(q.pop_front());
            end
            if (push) begin
                q.push_back('{adr: in_adr, data: in_data});
                m_csum = m_csum + {4'h0, in_data};
            end
            if (drop) begin
                m_ovf  = 1'b1;
                m_drop = ovf_clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
            end else if (ovf_clr) begin
                m_ovf  = 1'b0;
                m_drop = 8'h00;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pon_rst_i = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        in_data   = '0;
        in_adr    = '0;
        cycle();
        cycle();
        pon_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (level !== 4'd0 || out_valid !== 1'b0 || out_data !== 12'h0 || out_adr !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_fifo: level=%0d valid=%b data=%h adr=%h expected 0/0/0/0", level, out_valid, out_data, out_adr);
        end
        n_tests++;
        if (ovf !== 1'b0 || drop_cnt !== 8'h00 || checksum !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_status: ovf=%b drop=%0d csum=%h expected 0/0/0000", ovf, drop_cnt, checksum);
        end
    endtask

    task automatic test_first_word();
        do_reset();
        in_valid = 1'b1; in_data = 12'h123; in_adr = 13'h0001;
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 12'h123 || out_adr !== 13'h0001 || level !== 4'd1) begin
            n_fail++;
            $display("FAIL first_word: valid=%b data=%h adr=%h level=%0d expected 1/123/0001/1", out_valid, out_data, out_adr, level);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            in_valid = 1'b1; in_data = 12'(i); in_adr = 13'(12'h100 + i);
            cycle();
        end
        in_valid = 1'b0;
        n_tests++;
        if (level !== 4'd8 || ovf !== 1'b1 || drop_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL fill_status: level=%0d ovf=%b drop=%0d expected 8/1/1", level, ovf, drop_cnt);
        end
        n_tests++;
        if (out_data !== 12'h001 || out_adr !== 13'h101) begin
            n_fail++;
            $display("FAIL fill_head: got %h@%h expected 001@0101", out_data, out_adr);
        end
        n_tests++;
        if (checksum !== exp_csum(16'h0024)) begin
            n_fail++;
            $display("FAIL fill_checksum: got %h expected %h", checksum, exp_csum(16'h0024));
        end
    endtask

    task automatic test_full_push_pop();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = 12'(12'h00A + k); in_adr = 13'(13'h200 + k);
            cycle();
            n_tests++;
            if (level !== 4'd8 || drop_cnt !== 8'd1) begin
                n_fail++;
                $display("FAIL full_push_pop: level=%0d drop=%0d expected 8/1", level, drop_cnt);
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== 12'h005 || out_adr !== 13'h105) begin
                n_fail++;
                $display("FAIL head_hold: got %h@%h valid=%b expected 005@0105 valid=1", out_data, out_adr, out_valid);
            end
        end
    endtask

    task automatic test_drop_saturate();
        in_valid = 1'b1; out_ready = 1'b0; in_data = 12'hBAD;
        for (int k = 0; k < 254; k++) cycle();
        n_tests++;
        if (drop_cnt !== 8'hFF || ovf !== 1'b1 || level !== 4'd8) begin
            n_fail++;
            $display("FAIL drop_reach_max: drop=%0d ovf=%b level=%0d expected 255/1/8", drop_cnt, ovf, level);
        end
        cycle();
        n_tests++;
        if (drop_cnt !== 8'hFF) begin
            n_fail++;
            $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
        end
        ovf_clr = 1'b1;
        cycle();
        n_tests++;
        if (drop_cnt !== 8'd1 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_vs_drop: drop=%0d ovf=%b expected 1/1", drop_cnt, ovf);
        end
        in_valid = 1'b0;
        cycle();
        ovf_clr = 1'b0;
        n_tests++;
        if (drop_cnt !== 8'd0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: drop=%0d ovf=%b expected 0/0", drop_cnt, ovf);
        end
    endtask

    task automatic test_empty_no_bypass();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1; in_data = 12'h3C3; in_adr = 13'h1ABC;
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (level !== 4'd1 || out_valid !== 1'b1 || out_data !== 12'h3C3 || out_adr !== 13'h1ABC) begin
            n_fail++;
            $display("FAIL no_bypass: level=%0d valid=%b got %h@%h expected 1/1 3C3@1ABC", level, out_valid, out_data, out_adr);
        end
        cycle();
        n_tests++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL no_bypass_drain: level=%0d valid=%b expected 0/0", level, out_valid);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 12'hFFF; in_adr = 13'(k);
            cycle();
            n_tests++;
            if (level > 4'd1) begin
                n_fail++;
                $display("FAIL wrap_level: step %0d level=%0d expected <=1", k, level);
            end
        end
        in_valid = 1'b0;
        n_tests++;
        if (checksum !== exp_csum(16'hFFF0)) begin
            n_fail++;
            $display("FAIL wrap_checksum: got %h expected %h", checksum, exp_csum(16'hFFF0));
        end
        cycle();
        out_ready = 1'b0;
        n_tests++;
        if (level !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_drain: level=%0d expected 0", level);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 12'(12'h050 + k); in_adr = 13'(13'h0A0 + k);
            cycle();
        end
        n_tests++;
        if (level !== 4'd5) begin
            n_fail++;
            $display("FAIL mid_prefill: level=%0d expected 5", level);
        end
        pon_rst_i = 1'b1; out_ready = 1'b1; in_data = 12'h777;
        cycle();
        n_tests++;
        if (level !== 4'd0 || out_valid !== 1'b0 || checksum !== 16'h0000 || out_data !== 12'h0 || out_adr !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_reset: level=%0d valid=%b csum=%h got %h@%h expected 0/0/0000 000@0000", level, out_valid, checksum, out_data, out_adr);
        end
        pon_rst_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle();
        n_tests++;
        if (level !== 4'd0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after: level=%0d valid=%b expected 0/0", level, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) == 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            in_data   = 12'($urandom);
            in_adr    = 13'($urandom);
            cycle();
            n_tests++;
            if (level !== 4'(q.size()) || out_valid !== (q.size() != 0) || ovf !== m_ovf ||
                drop_cnt !== m_drop || checksum !== exp_csum(m_csum)) begin
                n_fail++;
                $display("FAIL random_state: cyc %0d level=%0d valid=%b ovf=%b drop=%0d csum=%h expected %0d/%b/%b/%0d/%h",
                         k, level, out_valid, ovf, drop_cnt, checksum, q.size(), (q.size() != 0), m_ovf, m_drop, exp_csum(m_csum));
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    endtask

    initial begin
        m_ovf = 1'b0; m_drop = 8'h00; m_csum = 16'h0000;
        test_reset();
        test_first_word();
        test_fill_overflow();
        test_full_push_pop();
        test_drop_saturate();
        test_empty_no_bypass();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_result_collector.md
PIPELINE_RESULT_COLLECTOR -- requirements
Module: pipeline_result_collector

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, FIFO entries, power of two, minimum 2.
REQ-002 The block SHALL have parameter DROP_W, default 8, width of the drop counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port pon_rst_i, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port in_data, input, 12, result word from the upstream pipeline's data_out.
REQ-006 The block SHALL have port in_valid, input, 1, qualifier from the upstream pipeline_valid.
REQ-007 The block SHALL have port in_adr, input, 13, program address from the upstream prog_adr_out.
REQ-008 The block SHALL have port out_data, output, 12, head-entry data.
REQ-009 The block SHALL have port out_adr, output, 13, head-entry address.
REQ-010 The block SHALL have port out_valid, output, 1, head entry present.
REQ-011 The block SHALL have port out_ready, input, 1, consumer accepts head.
REQ-012 The block SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.
REQ-013 The block SHALL have port ovf, output, 1, sticky overflow flag.
REQ-014 The block SHALL have port ovf_clr, input, 1, clears ovf and drop_cnt.
REQ-015 The block SHALL have port drop_cnt, output, DROP_W, count of dropped words.
REQ-016 The block SHALL have port checksum, output, 16, running sum of accepted words.

Function
REQ-017 Push: in_valid=1 and (level<DEPTH or pop this cycle); {in_adr,in_data} SHALL be written as one entry.
REQ-018 Pop: out_valid=1 and out_ready=1; head SHALL retire at that edge.
REQ-019 FIFO SHALL be first-word-fall-through; word pushed at edge N SHALL appear on out_* with out_valid=1 after edge N when previously empty (1-cycle latency).
REQ-020 out_valid SHALL equal (level!=0); out_data/out_adr SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 Full (level=DEPTH) with simultaneous push and pop: both SHALL occur, level stays DEPTH.
REQ-022 Empty with in_valid=1 and out_ready=1: no bypass; word SHALL be stored, level becomes 1.
REQ-023 Full, in_valid=1, no pop: word SHALL be dropped, ovf set to 1, drop_cnt incremented, saturating at all-ones.
REQ-024 ovf_clr=1 SHALL zero ovf and drop_cnt next edge; a drop in the same cycle SHALL win (ovf=1, drop_cnt=1).
REQ-025 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-026 checksum SHALL add zero-extended in_data per accepted push, modulo 2^16; dropped words SHALL not be added.

Reset
REQ-027 pon_rst_i=1 at an edge SHALL set level, pointers, out_valid, ovf, drop_cnt, checksum to 0; out_data/out_adr read 0.
REQ-028 Reset mid-operation SHALL discard all stored entries; inputs in that cycle SHALL be ignored.

Configuration
REQ-029 With macro COLLECTOR_CHECKSUM_EN defined, checksum SHALL behave per REQ-026.
REQ-030 Without COLLECTOR_CHECKSUM_EN, checksum SHALL be constant 0 and the adder/register SHALL be absent.

Structure
REQ-031 Package pipeline_collector_pkg SHALL hold DATA_W=12, ADR_W=13, CSUM_W=16 and the entry type {adr,data}.
REQ-032 Storage SHALL be sub-module collector_fifo (pointers, level, memory); top holds ovf, drop_cnt, checksum.

Verification
REQ-033 Reset, push 0x123@0x0001 with out_ready=0 -> next cycle out_valid=1, out_data=0x123, out_adr=0x0001, level=1.
REQ-034 DEPTH=8: push 9 words 0x001..0x009, out_ready=0 -> level=8, ovf=1, drop_cnt=1, head 0x001; checksum=0x0024.
REQ-035 Full, in_valid=1, out_ready=1 for 4 cycles -> level stays 8, drop_cnt unchanged, pops in push order.
REQ-036 drop_cnt=255 (DROP_W=8), one more drop -> drop_cnt=255; ovf_clr with drop same cycle -> drop_cnt=1, ovf=1.
REQ-037 16 pushes of 0xFFF with continuous pop -> checksum=0xFFF0, pointers wrap, level<=1 throughout.
REQ-038 Assert pon_rst_i with level=5 -> next cycle level=0, out_valid=0, checksum=0; build without COLLECTOR_CHECKSUM_EN -> checksum always 0.
